reg_req_apb_master: RTL and testbench

- Upstream master stage for the APB register-bank slaves.
- Converts a simple valid/ready register request channel (from the CSR crossbar or debug port) into single APB4 transfers, then returns read data and error on a valid/ready response channel.
- Issues one outstanding transfer at a time. Has an ACCESS-phase timeout so a hung slave cannot lock the requester.

---
 rtl/reg_bus_pkg.sv | 19 +
 rtl/reg_req_apb_master_if.sv | 53 +++++
 rtl/apb_timeout_cnt.sv | 40 ++++
 rtl/reg_req_apb_master.sv | 120 ++++++++++++
 tb/tb_reg_req_apb_master.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register bus: APB master FSM states, default
// bus widths and the response error code also used by the APB slave wrappers.
package reg_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // Response error flag values on rsp_err / p_slverr.
  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } reg_bus_state_e;

endpackage

// File: rtl/reg_req_apb_master_if.sv
// Bundle for reg_req_apb_master: request channel (req_*), response channel
// (rsp_*) and the APB4 master side (p_*).
//   master modport : the bridge itself
//   slave modport  : whatever sits around it (requester + APB slave)
interface reg_req_apb_master_if
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_strb;
  logic [2:0]            req_prot;

  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_W-1:0]     p_addr;
  logic [2:0]            p_prot;
  logic                  p_sel;
  logic                  p_enable;
  logic                  p_write;
  logic [DATA_W-1:0]     p_wdata;
  logic [DATA_W/8-1:0]   p_strb;
  logic                  p_ready;
  logic [DATA_W-1:0]     p_rdata;
  logic                  p_slverr;

  modport master (
    input  req_vld, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_rdy,
    output rsp_vld, rsp_rdata, rsp_err,
    input  rsp_rdy,
    output p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
    input  p_ready, p_rdata, p_slverr
  );

  modport slave (
    output req_vld, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_rdy,
    input  rsp_vld, rsp_rdata, rsp_err,
    output rsp_rdy,
    input  p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
    output p_ready, p_rdata, p_slverr
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog. Counts enabled cycles since the last clear and
// flags the cycle that would be the TIMEOUT-th one. Saturates, never wraps.
// TIMEOUT=0 removes the counter and never expires.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count (held while the transfer is in SETUP)
//   en         : count this cycle (transfer is in ACCESS)
//   expired    : this enabled cycle is the last one allowed
module apb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
      localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cnt_q <= '0;
        else if (clr)                  cnt_q <= '0;
        else if (en && cnt_q != LIMIT) cnt_q <= cnt_q + 1'b1;
      end

      // cnt_q holds the number of ACCESS cycles already spent, so the
      // TIMEOUT-th ACCESS cycle is the one where cnt_q == TIMEOUT-1.
      assign expired = en && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/reg_req_apb_master.sv
// Register request -> APB4 master bridge. Accepts one valid/ready request,
// runs a single SETUP/ACCESS transfer (or rejects a misaligned address
// without touching the bus) and returns rdata/err on the response channel.
// A hung slave is cut off after TIMEOUT ACCESS cycles with rsp_err=1.
//   clk, rst_n : clock, async active-low reset
//   bus        : reg_req_apb_master_if.master (req_*, rsp_*, p_*)
module reg_req_apb_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  reg_req_apb_master_if.master bus
);

  localparam int SW    = DATA_W / 8;
  localparam int OFF_W = $clog2(SW);

  reg_bus_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        prot_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     strb_q;
  logic              sel_q, en_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              misalign;
  logic              expired;

  assign misalign = |bus.req_addr[OFF_W-1:0];

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == SETUP),
    .en      (state_q == ACCESS),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_vld)               state_d = misalign ? RESP : SETUP;
      SETUP:                                  state_d = ACCESS;
      ACCESS:  if (bus.p_ready || expired)    state_d = RESP;
      RESP:    if (bus.rsp_rdy)               state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      prot_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= RSP_OK;
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_vld) begin
          if (misalign) begin
            err_q   <= RSP_ERR;
            rdata_q <= '0;
          end else begin
            sel_q   <= 1'b1;
            addr_q  <= bus.req_addr;
            prot_q  <= bus.req_prot;
            write_q <= bus.req_write;
            // Reads drive zero strobes/data on the bus.
            wdata_q <= bus.req_write ? bus.req_wdata : '0;
            strb_q  <= bus.req_write ? bus.req_strb  : '0;
          end
        end
        SETUP: en_q <= 1'b1;
        ACCESS: begin
          // p_ready beats a simultaneous timeout.
          if (bus.p_ready) begin
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            err_q   <= bus.p_slverr;
            rdata_q <= write_q ? '0 : bus.p_rdata;
          end else if (expired) begin
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            err_q   <= RSP_ERR;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_rdy   = (state_q == IDLE);
  assign bus.rsp_vld   = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.p_addr    = addr_q;
  assign bus.p_prot    = prot_q;
  assign bus.p_sel     = sel_q;
  assign bus.p_enable  = en_q;
  assign bus.p_write   = write_q;
  assign bus.p_wdata   = wdata_q;
  assign bus.p_strb    = strb_q;

endmodule

// File: tb/tb_reg_req_apb_master.sv
// Bench for reg_req_apb_master (TIMEOUT=8): directed vector table, random
// transactions scored against a transaction-level model, and a mid-transfer
// reset sequence. Inputs change and outputs are sampled on the falling edge.
module tb_reg_req_apb_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_req_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_req_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // wt: ACCESS cycles the slave stalls before p_ready (-1 = never).
  // exp_en: ACCESS cycles expected, exp_lat: accept -> rsp_vld cycles.
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wt;
    logic [31:0] rdata;
    logic        slverr;
    int          hold;
    int          exp_en;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_pwdata;
  } vec_t;

  int    n_chk = 0;
  int    n_pass = 0;
  string cur_tag = "";

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s %s: got %0h expected %0h", cur_tag, nm, got, exp);
  endtask

  // Behavioural APB slave: stalls slv_wait ACCESS cycles, drives junk on
  // its outputs whenever it is not completing a transfer.
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  int          acc_n = 0;

  always @(negedge clk) begin
    if (bus.p_sel && bus.p_enable) begin
      bus.p_ready  = (slv_wait >= 0 && acc_n == slv_wait);
      bus.p_rdata  = bus.p_ready ? slv_rdata : $urandom;
      bus.p_slverr = bus.p_ready ? slv_err : 1'($urandom);
      acc_n++;
    end else begin
      acc_n        = 0;
      bus.p_ready  = 1'($urandom);
      bus.p_rdata  = $urandom;
      bus.p_slverr = 1'($urandom);
    end
  end

  // Transaction-level expectation from the protocol rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   ready_at;
    r.exp_pstrb  = v.wr ? v.strb  : 4'h0;
    r.exp_pwdata = v.wr ? v.wdata : 32'h0;
    if (v.addr[1:0] != 2'b00) begin
      r.exp_en = 0; r.exp_lat = 1; r.exp_err = 1'b1; r.exp_rdata = '0;
    end else begin
      ready_at = (v.wt < 0) ? 1000 : v.wt + 1;
      if (ready_at <= TO) begin
        r.exp_en    = ready_at;
        r.exp_err   = v.slverr;
        r.exp_rdata = v.wr ? 32'h0 : v.rdata;
      end else begin
        r.exp_en = TO; r.exp_err = 1'b1; r.exp_rdata = '0;
      end
      r.exp_lat = r.exp_en + 2;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc, sel_n, en_n, sel_first, en_first;
    logic rdy_leak, unstable, got_rsp, hold_bad;
    logic [15:0] a; logic w; logic [3:0] s; logic [31:0] d; logic [2:0] pr;
    logic [31:0] r_d; logic r_e;
    a = '0; w = 1'b0; s = '0; d = '0; pr = '0;
    slv_wait = v.wt; slv_rdata = v.rdata; slv_err = v.slverr;
    @(negedge clk);
    chk("req_rdy idle", 64'(bus.req_rdy), 64'd1);
    bus.req_vld = 1'b1; bus.req_write = v.wr; bus.req_addr = v.addr;
    bus.req_wdata = v.wdata; bus.req_strb = v.strb; bus.req_prot = v.prot;
    @(negedge clk);
    bus.req_vld = 1'b0; bus.req_write = 1'($urandom); bus.req_addr = 16'($urandom);
    bus.req_wdata = $urandom; bus.req_strb = 4'($urandom); bus.req_prot = 3'($urandom);
    cyc = 1; sel_n = 0; en_n = 0; sel_first = 0; en_first = 0;
    rdy_leak = 1'b0; unstable = 1'b0; got_rsp = 1'b0;
    while (cyc <= 60) begin
      if (bus.rsp_vld) begin got_rsp = 1'b1; break; end
      if (bus.req_rdy) rdy_leak = 1'b1;
      if (bus.p_sel) begin
        if (sel_n == 0) begin
          sel_first = cyc; a = bus.p_addr; w = bus.p_write;
          s = bus.p_strb; d = bus.p_wdata; pr = bus.p_prot;
        end else if (bus.p_addr !== a || bus.p_write !== w || bus.p_strb !== s ||
                     bus.p_wdata !== d || bus.p_prot !== pr) unstable = 1'b1;
        sel_n++;
      end
      if (bus.p_enable) begin
        if (en_n == 0) en_first = cyc;
        en_n++;
      end
      @(negedge clk); cyc++;
    end
    chk("rsp seen", 64'(got_rsp), 64'd1);
    chk("latency", 64'(cyc), 64'(v.exp_lat));
    chk("p_enable cycles", 64'(en_n), 64'(v.exp_en));
    chk("req_rdy low in flight", 64'(rdy_leak), 64'd0);
    if (v.exp_en == 0) begin
      chk("no p_sel", 64'(sel_n), 64'd0);
    end else begin
      chk("p_sel cycles", 64'(sel_n), 64'(v.exp_en + 1));
      chk("p_sel first", 64'(sel_first), 64'd1);
      chk("p_enable first", 64'(en_first), 64'd2);
      chk("p_addr", 64'(a), 64'(v.addr));
      chk("p_write", 64'(w), 64'(v.wr));
      chk("p_prot", 64'(pr), 64'(v.prot));
      chk("p_strb", 64'(s), 64'(v.exp_pstrb));
      chk("p_wdata", 64'(d), 64'(v.exp_pwdata));
      chk("apb stable", 64'(unstable), 64'd0);
    end
    r_d = bus.rsp_rdata; r_e = bus.rsp_err;
    chk("rsp_err", 64'(r_e), 64'(v.exp_err));
    chk("rsp_rdata", 64'(r_d), 64'(v.exp_rdata));
    hold_bad = 1'b0;
    repeat (v.hold) begin
      @(negedge clk);
      if (!bus.rsp_vld || bus.rsp_rdata !== r_d || bus.rsp_err !== r_e || bus.req_rdy)
        hold_bad = 1'b1;
    end
    if (v.hold > 0) chk("rsp held", 64'(hold_bad), 64'd0);
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    bus.rsp_rdy = 1'b0;
    chk("rsp_vld drop", 64'(bus.rsp_vld), 64'd0);
    chk("req_rdy back", 64'(bus.req_rdy), 64'd1);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    logic bad;
    // wr addr wdata strb prot wt rdata slverr hold | en lat err rdata pstrb pwdata
    tbl[0] = '{1'b1, 16'h0004, 32'hA5A5_1234, 4'hF, 3'd0,  0, 32'h0,         1'b0, 0, 1, 3,  1'b0, 32'h0,         4'hF, 32'hA5A5_1234};
    tbl[1] = '{1'b0, 16'h0010, 32'hFFFF_FFFF, 4'hF, 3'd2,  3, 32'hDEAD_BEEF, 1'b0, 1, 4, 6,  1'b0, 32'hDEAD_BEEF, 4'h0, 32'h0};
    tbl[2] = '{1'b0, 16'h0020, 32'h0,         4'h0, 3'd0, -1, 32'h1111_1111, 1'b0, 0, 8, 10, 1'b1, 32'h0,         4'h0, 32'h0};
    tbl[3] = '{1'b0, 16'h0006, 32'h0,         4'h0, 3'd0,  0, 32'h2222_2222, 1'b0, 0, 0, 1,  1'b1, 32'h0,         4'h0, 32'h0};
    tbl[4] = '{1'b1, 16'h0008, 32'h1234_5678, 4'h3, 3'd5,  1, 32'h3333_3333, 1'b1, 5, 2, 4,  1'b1, 32'h0,         4'h3, 32'h1234_5678};
    tbl[5] = '{1'b0, 16'h0100, 32'h0,         4'hF, 3'd1,  7, 32'hCAFE_F00D, 1'b0, 0, 8, 10, 1'b0, 32'hCAFE_F00D, 4'h0, 32'h0};
    tbl[6] = '{1'b0, 16'h0104, 32'h0,         4'hF, 3'd0,  8, 32'h55AA_55AA, 1'b0, 0, 8, 10, 1'b1, 32'h0,         4'h0, 32'h0};
    tbl[7] = '{1'b1, 16'hFFFC, 32'h0BAD_F00D, 4'h9, 3'd7,  2, 32'h0,         1'b0, 2, 3, 5,  1'b0, 32'h0,         4'h9, 32'h0BAD_F00D};
    tbl[8] = '{1'b1, 16'h0001, 32'h7777_7777, 4'hF, 3'd0,  0, 32'h0,         1'b0, 0, 0, 1,  1'b1, 32'h0,         4'h0, 32'h0};

    bus.req_vld = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_strb = '0; bus.req_prot = '0; bus.rsp_rdy = 1'b0;

    cur_tag = "reset";
    #3;
    chk("req_rdy", 64'(bus.req_rdy), 64'd1);
    chk("rsp_vld", 64'(bus.rsp_vld), 64'd0);
    chk("rsp", {31'd0, bus.rsp_err, bus.rsp_rdata}, 64'd0);
    chk("p_ctl", {bus.p_sel, bus.p_enable, bus.p_write, bus.p_prot, bus.p_strb}, 64'd0);
    chk("p_addr/wdata", {bus.p_addr, bus.p_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_vec(tbl[i]);
    end

    // Reset during ACCESS against a slave that never answers.
    cur_tag = "midreset";
    slv_wait = -1;
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0040;
    @(negedge clk);
    bus.req_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("in ACCESS", {62'd0, bus.p_sel, bus.p_enable}, 64'd3);
    rst_n = 1'b0;
    #1;
    chk("p_sel", 64'(bus.p_sel), 64'd0);
    chk("p_enable", 64'(bus.p_enable), 64'd0);
    chk("rsp_vld", 64'(bus.rsp_vld), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_vld || bus.p_sel || !bus.req_rdy) bad = 1'b1;
    end
    chk("no stale rsp", 64'(bad), 64'd0);
    cur_tag = "post-reset";
    run_vec(tbl[1]);

    for (int i = 0; i < 40; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      rv.wr     = 1'($urandom);
      rv.addr   = 16'($urandom);
      if ($urandom_range(3) != 0) rv.addr[1:0] = 2'b00;
      rv.wdata  = $urandom;
      rv.strb   = 4'($urandom);
      rv.prot   = 3'($urandom);
      rv.wt     = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(10));
      rv.rdata  = $urandom;
      rv.slverr = ($urandom_range(3) == 0);
      rv.hold   = int'($urandom_range(3));
      rv = model(rv);
      run_vec(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
